muldiv_seq_unit: RTL and testbench
==================================

Name: muldiv_seq_unit

Overview:
Iterative RV32M multiply/divide responder. The execute stage hands it the same 4-bit ALU op encoding and operands it gives the combinational ALU for M-extension ops, via a valid/ready request channel. The unit computes the result over multiple cycles and returns it on a valid/ready response channel. It replaces single-cycle MUL/DIV paths so the ALU can meet timing, and the execute stage stalls on it.

Parameters:
XLEN, 32, operand/result width; must be even and >= 8
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of any in-flight op (pipeline flush)
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE
req_op  in  4  1010 MUL, 1011 MULH, 1100 MULHSU, 1101 MULHU, 1110 DIV, 1111 REM
req_op1  in  XLEN  rs1 operand / dividend
req_op2  in  XLEN  rs2 operand / divisor
resp_valid  out  1  result available, held until accepted
resp_ready  in  1  consumer accepts result
resp_result  out  XLEN  result, stable while resp_valid
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, resp_valid=0, resp_result=0, counter=0, internal registers 0. req_ready=1 and busy=0 once rst_n deasserts. Reset mid-operation discards the op with no response.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE: req_ready=1. Accept on req_valid&&req_ready at an edge. Latch op, operands, and sign flags. Load the magnitudes: MUL/MULH signed both, MULHSU op1 only, MULHU neither, DIV/REM signed both. Next state:
  - DONE for the special cases.
  - MUL for 1010-1101.
  - DIV for 1110-1111.
  - DONE with result 0 for any other opcode.
- Special cases resolve directly to DONE (1-cycle latency):
  - divisor==0: DIV gives all-ones; REM gives op1.
  - op1==100..0 and op2==all-ones: DIV gives op1; REM gives 0.
- MUL: radix-2 shift-add on unsigned magnitudes into a 2*XLEN accumulator, one bit per cycle, XLEN cycles. Negate the 2*XLEN product if the result sign is negative. MUL returns bits [XLEN-1:0]; MULH, MULHSU and MULHU return bits [2XLEN-1:XLEN].
- DIV: restoring division on magnitudes, one quotient bit per cycle, XLEN cycles.
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
- Latency: for MUL/DIV paths, resp_valid is high starting XLEN+1 edges after the accept edge (33 for XLEN=32). Special cases give resp_valid high 1 edge after accept.
- DONE: resp_valid=1 and resp_result is constant.
  - On resp_valid&&resp_ready, resp_valid drops at that edge and the state returns to IDLE.
  - req_ready is not asserted in DONE, so no same-cycle accept. Minimum issue interval is 2 cycles for special cases and XLEN+2 for iterative ops.
- Backpressure: resp_ready=0 holds DONE indefinitely with no result change.
- flush=1 at an edge in any state forces IDLE and resp_valid=0, overriding every other event including a same-edge request accept or response handshake. Outputs are not updated by the killed op.
- Request inputs are ignored outside IDLE. Operands need only be stable in the accept cycle.
- All arithmetic is modulo 2^XLEN / 2^(2XLEN). There is no overflow flag and no exceptions.

Test Plan:
- MUL 6*7 -> resp_valid exactly 33 cycles after accept, result 42. MUL -6*7 -> 0xFFFFFFD6. MULH -6*7 -> 0xFFFFFFFF. MULHSU -6,7 -> 0xFFFFFFFF. MULHU 6,7 -> 0. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 20/5 -> 4. DIV -20/5 -> 0xFFFFFFFC. REM 20,6 -> 2. REM -20,6 -> 0xFFFFFFFE. All at 33-cycle latency.
- Special cases at 1-cycle latency:
  - DIV 20/0 -> 0xFFFFFFFF; REM 20,0 -> 20.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Backpressure: hold resp_ready=0 for 10 cycles after result. resp_valid stays 1, result is stable, req_ready stays 0. Raising resp_ready gives IDLE next cycle and a new request is accepted.
- Flush/reset mid-op:
  - Assert flush at cycle 10 of a DIV -> IDLE next cycle, no resp_valid ever.
  - Assert rst_n=0 asynchronously at cycle 5 of a MUL -> resp_valid=0 immediately.
  - A following MUL 3*4 -> 12 correctly.
- Illegal op 0000 with req_valid -> result 0 after 1 cycle. Also check that a same-edge flush and request leaves the unit IDLE with no response.

Source files
------------

// File: rtl/muldiv_seq_unit.sv
// muldiv_seq_unit: iterative RV32M multiply/divide responder.
// Takes the execute-stage M-extension op plus operands on a valid/ready request
// channel. It computes the result one bit per cycle: shift-add for multiplies and
// restoring division for divides. The result is returned on a valid/ready response
// channel. Divide-by-zero, signed-overflow and unknown opcodes finish in one cycle.

module muldiv_seq_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [3:0] OP_MUL    = 4'b1010;
  localparam logic [3:0] OP_MULH   = 4'b1011;
  localparam logic [3:0] OP_MULHSU = 4'b1100;
  localparam logic [3:0] OP_MULHU  = 4'b1101;
  localparam logic [3:0] OP_DIV    = 4'b1110;
  localparam logic [3:0] OP_REM    = 4'b1111;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                resp_valid_q, resp_valid_d;

  // request decode
  logic                req_is_mul;
  logic                req_is_div;
  logic                req_sign1;
  logic                req_sign2;
  logic                req_neg1;
  logic                req_neg2;
  logic [XLEN-1:0]     req_mag1;
  logic [XLEN-1:0]     req_mag2;
  logic                req_div_zero;
  logic                req_div_ovf;

  // iteration datapath
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_acc_next;
  logic [XLEN:0]       div_cand;
  logic [XLEN:0]       div_diff;
  logic                div_ge;
  logic [XLEN-1:0]     div_rem_next;
  logic [2*XLEN-1:0]   div_acc_next;
  logic                last_iter;

  // final result shaping
  logic [2*XLEN-1:0]   prod_fixed;
  logic [XLEN-1:0]     mul_final;
  logic [XLEN-1:0]     div_pick;
  logic [XLEN-1:0]     div_final;

  // Classify the incoming op and form operand magnitudes and special-case flags
  always_comb begin
    req_is_mul = 1'b0;
    req_is_div = 1'b0;
    req_sign1  = 1'b0;
    req_sign2  = 1'b0;
    case (req_op)
      OP_MUL, OP_MULH: begin
        req_is_mul = 1'b1;
        req_sign1  = 1'b1;
        req_sign2  = 1'b1;
      end
      OP_MULHSU: begin
        req_is_mul = 1'b1;
        req_sign1  = 1'b1;
      end
      OP_MULHU: begin
        req_is_mul = 1'b1;
      end
      OP_DIV, OP_REM: begin
        req_is_div = 1'b1;
        req_sign1  = 1'b1;
        req_sign2  = 1'b1;
      end
      default: begin
        req_is_mul = 1'b0;
      end
    endcase
    req_neg1     = req_sign1 & req_op1[XLEN-1];
    req_neg2     = req_sign2 & req_op2[XLEN-1];
    req_mag1     = req_neg1 ? (-req_op1) : req_op1;
    req_mag2     = req_neg2 ? (-req_op2) : req_op2;
    req_div_zero = (req_op2 == '0);
    req_div_ovf  = (req_op1 == MOST_NEG) && (req_op2 == '1);
  end

  // One shift-add step and one restoring-divide step, both on the shared accumulator
  always_comb begin
    mul_sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_acc_next = {mul_sum, acc_q[XLEN-1:1]};

    div_cand     = acc_q[2*XLEN-1:XLEN-1];
    div_diff     = div_cand - {1'b0, mcand_q};
    div_ge       = ~div_diff[XLEN];
    div_rem_next = div_ge ? div_diff[XLEN-1:0] : div_cand[XLEN-1:0];
    div_acc_next = {div_rem_next, acc_q[XLEN-2:0], div_ge};

    last_iter    = (cnt_q == CNT_W'(XLEN - 1));
  end

  // Apply the result sign and pick the requested half or quotient/remainder
  always_comb begin
    prod_fixed = neg_q ? (-mul_acc_next) : mul_acc_next;
    mul_final  = (op_q == OP_MUL) ? prod_fixed[XLEN-1:0] : prod_fixed[2*XLEN-1:XLEN];
    div_pick   = (op_q == OP_DIV) ? div_acc_next[XLEN-1:0] : div_acc_next[2*XLEN-1:XLEN];
    div_final  = neg_q ? (-div_pick) : div_pick;
  end

  // Next-state and datapath register control; flush overrides everything
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    neg_d        = neg_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    result_d     = result_q;
    resp_valid_d = resp_valid_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          cnt_d = '0;
          neg_d = (req_op == OP_REM) ? req_neg1 : (req_neg1 ^ req_neg2);
          if (req_is_div) begin
            acc_d   = {{XLEN{1'b0}}, req_mag1};
            mcand_d = req_mag2;
          end else begin
            acc_d   = {{XLEN{1'b0}}, req_mag2};
            mcand_d = req_mag1;
          end
          if (req_is_div && req_div_zero) begin
            result_d     = (req_op == OP_DIV) ? '1 : req_op1;
            resp_valid_d = 1'b1;
            state_d      = S_DONE;
          end else if (req_is_div && req_div_ovf) begin
            result_d     = (req_op == OP_DIV) ? req_op1 : '0;
            resp_valid_d = 1'b1;
            state_d      = S_DONE;
          end else if (req_is_mul) begin
            state_d = S_MUL;
          end else if (req_is_div) begin
            state_d = S_DIV;
          end else begin
            result_d     = '0;
            resp_valid_d = 1'b1;
            state_d      = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_acc_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          result_d     = mul_final;
          resp_valid_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = div_acc_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          result_d     = div_final;
          resp_valid_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase

    if (flush) begin
      state_d      = S_IDLE;
      resp_valid_d = 1'b0;
      result_d     = result_q;
    end
  end

  // State and datapath registers, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      neg_q        <= 1'b0;
      acc_q        <= '0;
      mcand_q      <= '0;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      neg_q        <= neg_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// tb_muldiv_seq_unit: directed vectors with literal expectations, plus a
// cycle-level reference model built from plain 64-bit arithmetic that is
// compared against the handshake and result outputs on every cycle.

module tb_muldiv_seq_unit;

  localparam int XLEN = 32;

  localparam logic [3:0] OP_MUL    = 4'b1010;
  localparam logic [3:0] OP_MULH   = 4'b1011;
  localparam logic [3:0] OP_MULHSU = 4'b1100;
  localparam logic [3:0] OP_MULHU  = 4'b1101;
  localparam logic [3:0] OP_DIV    = 4'b1110;
  localparam logic [3:0] OP_REM    = 4'b1111;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [3:0]      req_op = 4'b0000;
  logic [XLEN-1:0] req_op1 = '0;
  logic [XLEN-1:0] req_op2 = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [XLEN-1:0] resp_result;
  logic            busy;

  int tests_run = 0;
  int tests_failed = 0;
  int edges = 0;
  logic seen_valid;

  // reference model state
  logic            m_busy = 1'b0;
  logic            m_valid = 1'b0;
  int              m_wait = 0;
  logic [XLEN-1:0] m_result = '0;

  muldiv_seq_unit #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Architectural result of an M-extension op using wide signed/unsigned arithmetic
  function automatic logic [XLEN-1:0] model_result(input logic [3:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    longint      q;
    logic [63:0] ua64;
    logic [63:0] ub64;
    logic [63:0] p;
    logic [XLEN-1:0] r;
    sa   = $signed(a);
    sb   = $signed(b);
    ub   = {32'b0, b};
    ua64 = {32'b0, a};
    ub64 = {32'b0, b};
    r    = '0;
    case (op)
      OP_MUL:    begin p = sa * sb;     r = p[31:0];  end
      OP_MULH:   begin p = sa * sb;     r = p[63:32]; end
      OP_MULHSU: begin p = sa * ub;     r = p[63:32]; end
      OP_MULHU:  begin p = ua64 * ub64; r = p[63:32]; end
      OP_DIV: begin
        if (b == '0) r = '1;
        else begin q = sa / sb; p = q; r = p[31:0]; end
      end
      OP_REM: begin
        if (b == '0) r = a;
        else begin q = sa % sb; p = q; r = p[31:0]; end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Edges from accept (inclusive) until the response is visible
  function automatic int model_latency(input logic [3:0] op,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    int lat;
    lat = 1;
    if (op >= OP_MUL && op <= OP_MULHU) lat = XLEN + 1;
    if (op == OP_DIV || op == OP_REM) begin
      if (b == '0) lat = 1;
      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) lat = 1;
      else lat = XLEN + 1;
    end
    return lat;
  endfunction

  // Transaction-level model: idle, working for a known number of edges, then holding a result
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_valid  <= 1'b0;
      m_wait   <= 0;
      m_result <= '0;
    end else if (flush) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_wait  <= 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy   <= 1'b1;
        m_result <= model_result(req_op, req_op1, req_op2);
        if (model_latency(req_op, req_op1, req_op2) == 1) m_valid <= 1'b1;
        else m_wait <= model_latency(req_op, req_op1, req_op2) - 1;
      end
    end else if (!m_valid) begin
      if (m_wait == 1) m_valid <= 1'b1;
      m_wait <= m_wait - 1;
    end else if (resp_ready) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
    end
  end

  task automatic compare(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle out of reset, the DUT handshake and held result must match the model
  always @(negedge clk) begin
    if (rst_n) begin
      compare("cyc req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
      compare("cyc busy", {31'b0, busy}, {31'b0, m_busy});
      compare("cyc resp_valid", {31'b0, resp_valid}, {31'b0, m_valid});
      if (m_valid) compare("cyc resp_result", resp_result, m_result);
    end
  end

  task automatic apply_stimulus(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req_op    = op;
    req_op1   = a;
    req_op2   = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op1   = $urandom;
    req_op2   = $urandom;
    edges     = 1;
  endtask

  task automatic check_output(input string name, input logic [XLEN-1:0] exp, input int exp_lat);
    while (!resp_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!resp_valid) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s timeout: resp_valid still 0 after %0d edges, expected by %0d", name, edges, exp_lat);
    end else begin
      compare({name, " result"}, resp_result, exp);
      compare({name, " model"}, m_result, exp);
      compare({name, " latency"}, 32'(edges), 32'(exp_lat));
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int exp_lat);
    apply_stimulus(op, a, b);
    check_output(name, exp, exp_lat);
    @(posedge clk);
    #1;
  endtask

  task automatic watch_no_response(input string name, input int cycles);
    seen_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen_valid = 1'b1;
    end
    compare(name, {31'b0, seen_valid}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2 rst_n = 1'b0;
    #18;
    compare("reset resp_valid", {31'b0, resp_valid}, 32'd0);
    compare("reset resp_result", resp_result, 32'd0);
    compare("reset busy", {31'b0, busy}, 32'd0);
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare("post-reset req_ready", {31'b0, req_ready}, 32'd1);
    compare("post-reset busy", {31'b0, busy}, 32'd0);

    // multiply family
    run_op("MUL 6*7",         OP_MUL,    32'd6,          32'd7,          32'd42,         33);
    run_op("MUL -6*7",        OP_MUL,    32'hFFFF_FFFA,  32'd7,          32'hFFFF_FFD6,  33);
    run_op("MULH -6*7",       OP_MULH,   32'hFFFF_FFFA,  32'd7,          32'hFFFF_FFFF,  33);
    run_op("MULHSU -6,7",     OP_MULHSU, 32'hFFFF_FFFA,  32'd7,          32'hFFFF_FFFF,  33);
    run_op("MULHSU -1,max",   OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  33);
    run_op("MULHU 6,7",       OP_MULHU,  32'd6,          32'd7,          32'd0,          33);
    run_op("MULHU max,max",   OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33);

    // divide family
    run_op("DIV 20/5",        OP_DIV,    32'd20,         32'd5,          32'd4,          33);
    run_op("DIV -20/5",       OP_DIV,    32'hFFFF_FFEC,  32'd5,          32'hFFFF_FFFC,  33);
    run_op("REM 20,6",        OP_REM,    32'd20,         32'd6,          32'd2,          33);
    run_op("REM -20,6",       OP_REM,    32'hFFFF_FFEC,  32'd6,          32'hFFFF_FFFE,  33);
    run_op("DIV 7/-2",        OP_DIV,    32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33);
    run_op("REM 7,-2",        OP_REM,    32'd7,          32'hFFFF_FFFE,  32'd1,          33);
    run_op("REM -7,-2",       OP_REM,    32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  33);

    // single-cycle special cases and unknown opcode
    run_op("DIV 20/0",        OP_DIV,    32'd20,         32'd0,          32'hFFFF_FFFF,  1);
    run_op("REM 20,0",        OP_REM,    32'd20,         32'd0,          32'd20,         1);
    run_op("DIV ovf",         OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
    run_op("REM ovf",         OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);
    run_op("illegal op 0000", 4'b0000,   32'd9,          32'd9,          32'd0,          1);

    // backpressure: result held, requests ignored, then released into a new accept
    resp_ready = 1'b0;
    apply_stimulus(OP_DIV, 32'd100, 32'd7);
    check_output("bp DIV 100/7", 32'd14, 33);
    req_op    = OP_MUL;
    req_op1   = 32'd123;
    req_op2   = 32'd456;
    req_valid = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      compare("bp resp_valid held", {31'b0, resp_valid}, 32'd1);
      compare("bp result stable", resp_result, 32'd14);
      compare("bp req_ready low", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    req_op1    = 32'd2;
    req_op2    = 32'd5;
    @(posedge clk);
    #1;
    compare("bp release req_ready", {31'b0, req_ready}, 32'd1);
    compare("bp release busy", {31'b0, busy}, 32'd0);
    apply_stimulus(OP_MUL, 32'd2, 32'd5);
    check_output("bp next MUL 2*5", 32'd10, 33);
    @(posedge clk);
    #1;

    // flush during a divide
    apply_stimulus(OP_DIV, 32'd1000, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    compare("flush busy", {31'b0, busy}, 32'd0);
    compare("flush resp_valid", {31'b0, resp_valid}, 32'd0);
    compare("flush req_ready", {31'b0, req_ready}, 32'd1);
    watch_no_response("flush no response", 40);

    // same-edge flush and request accept
    req_op    = OP_MUL;
    req_op1   = 32'd5;
    req_op2   = 32'd5;
    req_valid = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    compare("flush+req busy", {31'b0, busy}, 32'd0);
    watch_no_response("flush+req no response", 40);

    // asynchronous reset while holding a result
    resp_ready = 1'b0;
    apply_stimulus(OP_DIV, 32'd20, 32'd0);
    check_output("pre-reset DIV 20/0", 32'hFFFF_FFFF, 1);
    #2 rst_n = 1'b0;
    #1;
    compare("async reset resp_valid", {31'b0, resp_valid}, 32'd0);
    compare("async reset resp_result", resp_result, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;

    // asynchronous reset in the middle of a multiply
    apply_stimulus(OP_MUL, 32'd1234, 32'd5678);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    compare("mid-MUL reset resp_valid", {31'b0, resp_valid}, 32'd0);
    compare("mid-MUL reset busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("MUL 3*4 after reset", OP_MUL, 32'd3, 32'd4, 32'd12, 33);

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
